// File: rtl/state_dump_unit.sv
// rtl/state_dump_unit.sv - post-halt register-file and data-memory dump onto a valid/ready item stream
module state_dump_unit #(
    parameter int          REG_COUNT = 32,
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] MEM_BASE  = 32'h0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        regSel,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        memSel,
    output logic        memRead,
    output logic [31:0] memAddr,
    input  logic [31:0] memData,
    output logic        outValid,
    input  logic        outReady,
    output logic        outKind,
    output logic [15:0] outIndex,
    output logic [31:0] outData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG_RD,
        S_REG_OUT,
        S_MEM_ADDR,
        S_MEM_WAIT,
        S_MEM_OUT,
        S_DONE
    } state_t;

    localparam logic [15:0] L_REG_LAST = 16'(REG_COUNT - 1);
    localparam logic [15:0] L_MEM_LAST = (MEM_WORDS == 0) ? 16'd0 : 16'(MEM_WORDS - 1);
    localparam bit          L_HAS_MEM  = (MEM_WORDS != 0);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_index;
    logic [15:0] w_index_next;
    logic        r_out_valid;
    logic        r_out_kind;
    logic [15:0] r_out_index;
    logic [31:0] r_out_data;
    logic        w_hs;
    logic        w_load_reg;
    logic        w_load_mem;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_index <= 16'd0;
        end else begin
            r_state <= w_next;
            r_index <= w_index_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_index_next = r_index;
        w_hs         = r_out_valid & outReady;
        w_load_reg   = 1'b0;
        w_load_mem   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        regSel       = 1'b0;
        memSel       = 1'b0;
        memRead      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_index_next = 16'd0;
                    w_next       = S_REG_RD;
                end
            end
            S_REG_RD: begin
                regSel     = 1'b1;
                w_load_reg = 1'b1;
                w_next     = S_REG_OUT;
            end
            S_REG_OUT: begin
                regSel = 1'b1;
                if (w_hs) begin
                    if (r_index == L_REG_LAST) begin
                        w_index_next = 16'd0;
                        w_next       = L_HAS_MEM ? S_MEM_ADDR : S_DONE;
                    end else begin
                        w_index_next = r_index + 16'd1;
                        w_next       = S_REG_RD;
                    end
                end
            end
            S_MEM_ADDR: begin
                memSel  = 1'b1;
                memRead = 1'b1;
                w_next  = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                memSel     = 1'b1;
                memRead    = 1'b1;
                w_load_mem = 1'b1;
                w_next     = S_MEM_OUT;
            end
            S_MEM_OUT: begin
                memSel = 1'b1;
                if (w_hs) begin
                    if (r_index == L_MEM_LAST) begin
                        w_next = S_DONE;
                    end else begin
                        w_index_next = r_index + 16'd1;
                        w_next       = S_MEM_ADDR;
                    end
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Addresses are forced to zero outside their phase so the datapath muxes see a quiet bus.
    assign regAddr = regSel ? r_index[4:0] : 5'd0;
    assign memAddr = memRead ? (MEM_BASE + {14'd0, r_index, 2'b00}) : 32'd0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_out_valid <= 1'b0;
            r_out_kind  <= 1'b0;
            r_out_index <= 16'd0;
            r_out_data  <= 32'd0;
        end else if (w_load_reg) begin
            r_out_valid <= 1'b1;
            r_out_kind  <= 1'b0;
            r_out_index <= r_index;
            r_out_data  <= regData;
        end else if (w_load_mem) begin
            r_out_valid <= 1'b1;
            r_out_kind  <= 1'b1;
            r_out_index <= r_index;
            r_out_data  <= memData;
        end else if (w_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign outValid = r_out_valid;
    assign outKind  = r_out_kind;
    assign outIndex = r_out_index;
    assign outData  = r_out_data;

endmodule

// File: tb/tb_state_dump_unit.sv
// tb/tb_state_dump_unit.sv - scoreboard bench for state_dump_unit over three parameter sets
module tb_state_dump_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN;
    logic        start_v     [3];
    logic        out_ready;
    logic        busy_v      [3];
    logic        done_v      [3];
    logic        reg_sel_v   [3];
    logic        mem_sel_v   [3];
    logic        mem_read_v  [3];
    logic        out_valid_v [3];
    logic        out_kind_v  [3];
    logic [4:0]  reg_addr_v  [3];
    logic [31:0] reg_data_v  [3];
    logic [31:0] mem_addr_v  [3];
    logic [31:0] mem_data_v  [3];
    logic [31:0] out_data_v  [3];
    logic [15:0] out_index_v [3];

    state_dump_unit #(.REG_COUNT(32), .MEM_WORDS(4), .MEM_BASE(32'h0)) u_dut0 (
        .clk(clk), .resetN(resetN), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .regSel(reg_sel_v[0]), .regAddr(reg_addr_v[0]), .regData(reg_data_v[0]),
        .memSel(mem_sel_v[0]), .memRead(mem_read_v[0]), .memAddr(mem_addr_v[0]), .memData(mem_data_v[0]),
        .outValid(out_valid_v[0]), .outReady(out_ready), .outKind(out_kind_v[0]),
        .outIndex(out_index_v[0]), .outData(out_data_v[0]));

    state_dump_unit #(.REG_COUNT(32), .MEM_WORDS(0), .MEM_BASE(32'h0)) u_dut1 (
        .clk(clk), .resetN(resetN), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .regSel(reg_sel_v[1]), .regAddr(reg_addr_v[1]), .regData(reg_data_v[1]),
        .memSel(mem_sel_v[1]), .memRead(mem_read_v[1]), .memAddr(mem_addr_v[1]), .memData(mem_data_v[1]),
        .outValid(out_valid_v[1]), .outReady(out_ready), .outKind(out_kind_v[1]),
        .outIndex(out_index_v[1]), .outData(out_data_v[1]));

    state_dump_unit #(.REG_COUNT(1), .MEM_WORDS(3), .MEM_BASE(32'hFFFF_FFF8)) u_dut2 (
        .clk(clk), .resetN(resetN), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .regSel(reg_sel_v[2]), .regAddr(reg_addr_v[2]), .regData(reg_data_v[2]),
        .memSel(mem_sel_v[2]), .memRead(mem_read_v[2]), .memAddr(mem_addr_v[2]), .memData(mem_data_v[2]),
        .outValid(out_valid_v[2]), .outReady(out_ready), .outKind(out_kind_v[2]),
        .outIndex(out_index_v[2]), .outData(out_data_v[2]));

    typedef struct packed {
        logic        kind;
        logic [15:0] index;
        logic [31:0] data;
    } item_t;

    typedef struct {
        int          dut;
        int          mode;
        int          mid_start;
        int          exp_done;
        int          n_regs;
        int          n_mems;
        logic [31:0] base;
        bit          exp_memsel;
    } vec_t;

    item_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] got_addr_q[$];

    int total = 0;
    int bad = 0;
    int act = 0;
    int rdy_mode = 0;
    int cycle_no = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int viol = 0;
    int stall_cnt = 0;
    int done_at[2];
    bit memsel_seen = 1'b0;

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'hFFFF_FFF8 : 32'h0;
    endfunction

    always_comb begin
        for (int d = 0; d < 3; d++) reg_data_v[d] = 32'h100 + {27'd0, reg_addr_v[d]};
    end

    // Data memory answers one cycle after the address is presented.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++)
            if (mem_read_v[d]) mem_data_v[d] <= 32'hA000_0000 + ((mem_addr_v[d] - base_of(d)) >> 2);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    initial begin
        item_t cur;
        item_t e;
        logic  hs;
        logic  prev_valid = 1'b0;
        logic  prev_hs = 1'b0;
        logic  prev_mread = 1'b0;
        item_t prev_item = '0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
                prev_mread = 1'b0;
            end else begin
                cycle_no++;
                cur = {out_kind_v[act], out_index_v[act], out_data_v[act]};
                hs  = out_valid_v[act] && out_ready;
                if (done_v[act]) begin
                    if (done_cnt < 2) done_at[done_cnt] = cycle_no;
                    done_cnt++;
                end
                if (busy_v[act]) busy_cnt++;
                if (reg_sel_v[act] && mem_sel_v[act]) viol++;
                if (mem_sel_v[act]) begin
                    memsel_seen = 1'b1;
                    if (exp_q.size() > 0 && exp_q[0].kind == 1'b0) viol++;
                end
                if (mem_read_v[act] && !prev_mread) got_addr_q.push_back(mem_addr_v[act]);
                if (prev_valid && !prev_hs && (!out_valid_v[act] || cur != prev_item)) viol++;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_item: got %0h want none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("item", 64'(cur), 64'(e));
                    end
                end
                prev_valid = out_valid_v[act];
                prev_hs    = hs;
                prev_mread = mem_read_v[act];
                prev_item  = cur;
            end
        end
    end

    // Random backpressure, with a fixed 5-cycle stall on the register-31 item.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
            end else if (out_valid_v[act] && !out_kind_v[act] && out_index_v[act] == 16'd31) begin
                if (stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic setup(input vec_t v, input int reps);
        act         = v.dut;
        rdy_mode    = v.mode;
        stall_cnt   = 0;
        done_cnt    = 0;
        busy_cnt    = 0;
        viol        = 0;
        memsel_seen = 1'b0;
        done_at[0]  = 0;
        done_at[1]  = 0;
        exp_q.delete();
        exp_addr_q.delete();
        got_addr_q.delete();
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < v.n_regs; k++)
                exp_q.push_back(item_t'{1'b0, 16'(k), 32'h100 + 32'(k)});
            for (int w = 0; w < v.n_mems; w++) begin
                exp_q.push_back(item_t'{1'b1, 16'(w), 32'hA000_0000 + 32'(w)});
                exp_addr_q.push_back(v.base + 32'(4 * w));
            end
        end
    endtask

    task automatic final_checks(input vec_t v);
        chk("items_left", 64'(exp_q.size()), 64'd0);
        chk("addr_count", 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
        for (int i = 0; i < got_addr_q.size() && i < exp_addr_q.size(); i++)
            chk("mem_addr", 64'(got_addr_q[i]), 64'(exp_addr_q[i]));
        chk("mem_sel_seen", 64'(memsel_seen), 64'(v.exp_memsel));
        chk("protocol", 64'(viol), 64'd0);
    endtask

    task automatic run_case(input vec_t v);
        setup(v, 1);
        @(posedge clk); #1;
        start_v[v.dut] = 1'b1;
        @(posedge clk); #1;
        start_v[v.dut] = 1'b0;
        cycle_no = 0;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            start_v[v.dut] = (v.mid_start != 0 && cycle_no == 10);
        end
        start_v[v.dut] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", 64'(done_cnt), 64'd1);
        if (v.exp_done >= 0) begin
            chk("done_cycle", 64'(done_at[0]), 64'(v.exp_done));
            chk("busy_cycles", 64'(busy_cnt), 64'(v.exp_done));
        end
        final_checks(v);
    endtask

    vec_t tbl[5];

    initial begin
        bit found;
        tbl[0] = '{0, 0, 0, 77, 32, 4, 32'h0, 1'b1};
        tbl[1] = '{0, 1, 0, -1, 32, 4, 32'h0, 1'b1};
        tbl[2] = '{1, 0, 0, 65, 32, 0, 32'h0, 1'b0};
        tbl[3] = '{2, 0, 0, 12, 1, 3, 32'hFFFF_FFF8, 1'b1};
        tbl[4] = '{0, 0, 1, 77, 32, 4, 32'h0, 1'b1};

        resetN = 1'b0;
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'({busy_v[0], done_v[0], reg_sel_v[0], mem_sel_v[0], mem_read_v[0],
                                out_valid_v[0], mem_addr_v[0], reg_addr_v[0]}), 64'd0);
        resetN = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 64'({busy_v[0], busy_v[1], busy_v[2]}), 64'd0);

        for (int t = 0; t < 5; t++) run_case(tbl[t]);

        // start held high: second dump follows one IDLE cycle after the done pulse
        setup(tbl[0], 2);
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        cycle_no = 0;
        for (int i = 0; i < 3000 && done_cnt < 2; i++) begin
            @(posedge clk); #1;
        end
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("hold_done_count", 64'(done_cnt), 64'd2);
        chk("hold_done1", 64'(done_at[0]), 64'd77);
        chk("hold_done2", 64'(done_at[1]), 64'd155);
        chk("hold_busy", 64'(busy_cnt), 64'd154);
        final_checks(tbl[0]);

        // asynchronous reset during MEM_WAIT of word 2, then a clean restart
        setup(tbl[0], 1);
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        cycle_no = 0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (mem_read_v[0] && mem_addr_v[0] == 32'd8) found = 1'b1;
        end
        chk("reach_word2", 64'(found), 64'd1);
        @(posedge clk); #2;
        chk("pre_reset", 64'({busy_v[0], mem_sel_v[0], mem_read_v[0]}), 64'd7);
        resetN = 1'b0;
        #1;
        chk("async_reset", 64'({busy_v[0], done_v[0], reg_sel_v[0], mem_sel_v[0], mem_read_v[0],
                                out_valid_v[0], mem_addr_v[0], reg_addr_v[0]}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk); #1;
        run_case(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
